// File: rtl/uart_transmitter_pkg.sv
// ============================================================================
// Module      : uart_transmitter_pkg
// Description : Shared UART frame constants and transmitter state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_transmitter_pkg;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_transmitter_if.sv
// ============================================================================
// Module      : uart_transmitter_if
// Description : Byte handshake, flow control and serial line of the UART TX.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface uart_transmitter_if;

    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       clear_to_send;
    logic       tx_out;
    logic       tx_byte_done_out;
    logic       busy_out;

    modport master (
        output tx_byte,
        output tx_byte_valid,
        output clear_to_send,
        input  tx_out,
        input  tx_byte_done_out,
        input  busy_out
    );

    modport slave (
        input  tx_byte,
        input  tx_byte_valid,
        input  clear_to_send,
        output tx_out,
        output tx_byte_done_out,
        output busy_out
    );

endinterface

`default_nettype wire

// File: rtl/uart_transmitter.sv
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter with clear-to-send gating of frame start.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int ClocksPerBaud = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_transmitter_if.slave bus
);

    localparam int CW = $clog2(ClocksPerBaud);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] c_baud_last = CW'(ClocksPerBaud - 1);
    localparam logic [BW-1:0] c_bit_last  = BW'(DATA_BITS - 1);

    tx_state_t     r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [BW-1:0] r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_done;
    logic          r_busy;

    logic          w_baud_end;
    logic          w_capture;

    assign w_baud_end = (r_baud_cnt == '0);
    // Capturing on the last STOP cycle lets frames run back-to-back with no idle gap.
    assign w_capture  = ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_end))
                        && bus.tx_byte_valid && bus.clear_to_send;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_state    <= ST_START;
                r_shift    <= bus.tx_byte;
                r_baud_cnt <= c_baud_last;
                r_bit_idx  <= '0;
                r_tx       <= 1'b0;
                r_done     <= 1'b1;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (w_baud_end) begin
                            r_state    <= ST_DATA;
                            r_baud_cnt <= c_baud_last;
                            r_tx       <= r_shift[0];
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (w_baud_end) begin
                            r_baud_cnt <= c_baud_last;
                            if (r_bit_idx == c_bit_last) begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                                r_shift   <= {1'b0, r_shift[7:1]};
                                r_tx      <= r_shift[1];
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (w_baud_end) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tx_out           = r_tx;
    assign bus.tx_byte_done_out = r_done;
    assign bus.busy_out         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Randomized self-checking bench with a frame-level line model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_transmitter;

    localparam int CPB          = 8;
    localparam int FRAME_CYCLES = 10 * CPB;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic [7:0] seq [4];

    uart_transmitter_if bus_if ();

    uart_transmitter #(.ClocksPerBaud(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line level of bit slot k of an 8N1 frame: start, LSB-first data, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic check_idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_tx"}, bus_if.tx_out, 1'b1);
            check({tag, "_done"}, bus_if.tx_byte_done_out, 1'b0);
            check({tag, "_busy"}, bus_if.busy_out, 1'b0);
        end
    endtask

    // Sends seq[0..n-1] back-to-back from idle; CTS and stale tx_byte are
    // scrambled mid-frame, and each frame is also decoded mid-bit like a receiver.
    task automatic frame_seq(input int n);
        logic       line [FRAME_CYCLES];
        logic [7:0] rx;
        bus_if.tx_byte       = seq[0];
        bus_if.tx_byte_valid = 1'b1;
        bus_if.clear_to_send = 1'b1;
        @(posedge clk);
        for (int f = 0; f < n; f++) begin
            for (int s = 0; s < FRAME_CYCLES; s++) begin
                @(negedge clk);
                line[s] = bus_if.tx_out;
                check("tx", bus_if.tx_out, frame_bit(seq[f], s / CPB));
                check("done", bus_if.tx_byte_done_out, (s == 0));
                check("busy", bus_if.busy_out, 1'b1);
                if (s == 0 && f + 1 < n) begin
                    bus_if.tx_byte = seq[f+1];
                end else if (f + 1 == n) begin
                    bus_if.tx_byte_valid = 1'b0;
                    bus_if.tx_byte       = 8'($urandom);
                end
                bus_if.clear_to_send = (s == FRAME_CYCLES - 1 && f + 1 < n) ? 1'b1 : 1'($urandom);
            end
            for (int i = 0; i < 8; i++) rx[i] = line[(i + 1) * CPB + CPB / 2];
            check("rx_byte", rx, seq[f]);
        end
        @(negedge clk);
        check("end_busy", bus_if.busy_out, 1'b0);
        check("end_tx", bus_if.tx_out, 1'b1);
        check("end_done", bus_if.tx_byte_done_out, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n                = 1'b0;
        bus_if.tx_byte       = 8'h00;
        bus_if.tx_byte_valid = 1'b0;
        bus_if.clear_to_send = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", bus_if.tx_out, 1'b1);
        check("rst_done", bus_if.tx_byte_done_out, 1'b0);
        check("rst_busy", bus_if.busy_out, 1'b0);
        rst_n = 1'b1;

        // Capture on the very first edge out of reset.
        seq[0] = 8'h55;
        frame_seq(1);
        check_idle(3, "gap");

        seq[0] = 8'h01;
        frame_seq(1);

        seq[0] = 8'hA3;
        seq[1] = 8'h3C;
        frame_seq(2);

        // Valid byte held while CTS is low must not start a frame.
        bus_if.tx_byte       = 8'hC7;
        bus_if.tx_byte_valid = 1'b1;
        bus_if.clear_to_send = 1'b0;
        check_idle(50, "cts_wait");
        seq[0] = 8'hC7;
        frame_seq(1);

        // Reset pulse during DATA bit 3 abandons the frame.
        bus_if.tx_byte       = 8'h96;
        bus_if.tx_byte_valid = 1'b1;
        bus_if.clear_to_send = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 34; s++) begin
            @(negedge clk);
            check("abort_tx", bus_if.tx_out, frame_bit(8'h96, s / CPB));
            bus_if.tx_byte_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_tx_hi", bus_if.tx_out, 1'b1);
        check("abort_busy", bus_if.busy_out, 1'b0);
        check_idle(30, "post_abort");

        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) seq[i] = 8'($urandom);
            frame_seq(n);
            check_idle($urandom_range(0, 5), "rand_gap");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter ClocksPerBaud, default 8, clock cycles per baud period; SHALL be an integer >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 tx_byte  input  8  payload byte; sampled only on capture.
REQ-005 tx_byte_valid  input  1  producer has a byte to send; SHALL be held high until tx_byte_done_out is seen.
REQ-006 clear_to_send  input  1  far end may accept a frame; gates frame start only.
REQ-007 tx_out  output  1  serial line; idle level 1.
REQ-008 tx_byte_done_out  output  1  one-cycle pulse, byte captured.
REQ-009 busy_out  output  1  high whenever state is not IDLE.

Function
REQ-010 States: IDLE, START, DATA, STOP; encoding 0..3, IDLE = 0.
REQ-011 Capture condition: (state IDLE, or final cycle of STOP) and tx_byte_valid and clear_to_send.
REQ-012 On capture: tx_byte latched into shift register; next state START; baud countdown loaded with ClocksPerBaud-1; tx_byte_done_out high the following cycle only.
REQ-013 tx_out SHALL be registered: 0 in START, current data bit in DATA, 1 in STOP and IDLE.
REQ-014 START, each DATA bit and STOP SHALL each hold tx_out for exactly ClocksPerBaud cycles.
REQ-015 Data SHALL be sent LSB first, 8 bits, no parity, one stop bit.
REQ-016 DATA -> STOP after bit 7 completes; STOP -> IDLE at the end of its last cycle unless the capture condition holds, in which case STOP -> START.
REQ-017 Back-to-back frames SHALL therefore be exactly 10*ClocksPerBaud cycles apart with no idle gap.
REQ-018 clear_to_send deasserting mid-frame SHALL NOT abort or stall the frame.
REQ-019 tx_byte / tx_byte_valid changes after capture SHALL NOT affect the frame in flight.
REQ-020 A valid byte present while clear_to_send is low SHALL wait in IDLE indefinitely; tx_out stays 1.
REQ-021 The baud countdown width SHALL be clog2(ClocksPerBaud); no wrap beyond ClocksPerBaud-1.

Reset
REQ-022 While rst_n is 0 at a clock edge: state IDLE, tx_out 1, tx_byte_done_out 0, busy_out 0, countdown and bit index 0.
REQ-023 Reset mid-frame SHALL abandon the frame: tx_out returns to 1 on the next edge; no done pulse; the byte is not resent.
REQ-024 The first capture SHALL be possible on the first cycle with rst_n high.

Structure
REQ-025 State encodings and the frame constants (8 data bits, 1 stop bit) SHALL live in the shared UART include also used by uart_receiver, so both ends agree.
REQ-026 No sub-module; one module with a single clocked process plus next-state logic.

Verification (ClocksPerBaud = 8)
REQ-027 Reset, then valid with 8'h55 and CTS high -> done pulse 1 cycle after capture; tx_out: 0 for 8 cycles, then 1,0,1,0,1,0,1,0 for 8 cycles each, then 1; busy_out low 80 cycles after capture.
REQ-028 Loopback into uart_receiver, send 8'h01 -> rx_byte_out = 8'h01 with rx_byte_valid_out high before the stop bit ends.
REQ-029 Valid 8'hA3 then 8'h3C held back-to-back -> second start bit begins exactly 80 cycles after the first; exactly two done pulses.
REQ-030 Valid high, CTS low for 50 cycles -> tx_out stays 1, no done pulse; CTS rises -> capture next cycle.
REQ-031 rst_n low for 1 cycle during DATA bit 3 -> tx_out 1, busy_out 0 on the next edge; no further transitions while valid is low.
REQ-032 CTS drops during DATA, tx_byte changed to 8'hFF -> original frame completes bit-exact.
